// File: rtl/wave_mode_if.sv
// Waveform-mode sequencer bus: the request side (step/load pulses, enable mask),
// the mute handshake with the output stage, and the sequencer status.
//   master : request source / output stage (drives requests and mute_ack)
//   slave  : wave_mode_seq (drives mode, mute_req, busy, changed)
interface wave_mode_if #(
  parameter int NUM_MODES = 4
);
  localparam int MODE_W = $clog2(NUM_MODES);

  logic                 next_edge;
  logic                 prev_edge;
  logic                 load_en;
  logic [MODE_W-1:0]    load_mode;
  logic [NUM_MODES-1:0] mode_enable;
  logic                 mute_ack;
  logic [MODE_W-1:0]    mode;
  logic                 mute_req;
  logic                 busy;
  logic                 changed;

  modport master (
    output next_edge, prev_edge, load_en, load_mode, mode_enable, mute_ack,
    input  mode, mute_req, busy, changed
  );

  modport slave (
    input  next_edge, prev_edge, load_en, load_mode, mode_enable, mute_ack,
    output mode, mute_req, busy, changed
  );
endinterface

// File: rtl/wave_mode_seq.sv
// Waveform-mode sequencer. Steps forward/backward through the enabled modes or
// jumps to a loaded mode; every change is wrapped in a mute handshake:
// IDLE -> MUTE_WAIT (ack or timeout) -> SWITCH (mode updates) -> HOLD -> IDLE.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : wave_mode_if.slave (requests, enable mask, mute_ack in;
//              mode, mute_req, busy, changed out; all outputs registered)
module wave_mode_seq #(
  parameter int NUM_MODES   = 4,
  parameter int RESET_MODE  = 0,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  wave_mode_if.slave  bus
);
  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int WCW    = $clog2(ACK_TIMEOUT + 1);
  localparam int HCW    = $clog2(HOLD_CYCLES + 1);
  localparam logic [WCW-1:0] ACK_LAST  = WCW'(ACK_TIMEOUT - 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUTE_WAIT, SWITCH, HOLD} state_t;

  state_t            state;
  logic [MODE_W-1:0] mode_q, tgt_q;
  logic              mute_q, busy_q, chg_q;
  logic [WCW-1:0]    wcnt;
  logic [HCW-1:0]    hcnt;

  // Target search. Offsets start at 1 so the current mode is never a candidate;
  // if nothing else is enabled the request degenerates to a no-op.
  logic [MODE_W-1:0] nxt_tgt, prv_tgt, req_tgt;
  logic              nxt_ok, prv_ok, req_ok;
  int                in_i, ip_i;

  always_comb begin
    nxt_tgt = mode_q;
    prv_tgt = mode_q;
    nxt_ok  = 1'b0;
    prv_ok  = 1'b0;
    in_i    = 0;
    ip_i    = 0;
    for (int k = 1; k < NUM_MODES; k++) begin
      in_i = int'(mode_q) + k;
      if (in_i >= NUM_MODES) in_i = in_i - NUM_MODES;
      ip_i = int'(mode_q) + NUM_MODES - k;
      if (ip_i >= NUM_MODES) ip_i = ip_i - NUM_MODES;
      if (!nxt_ok && bus.mode_enable[in_i]) begin
        nxt_ok  = 1'b1;
        nxt_tgt = MODE_W'(in_i);
      end
      if (!prv_ok && bus.mode_enable[ip_i]) begin
        prv_ok  = 1'b1;
        prv_tgt = MODE_W'(ip_i);
      end
    end
  end

  // load_en outranks the step pulses even when the load itself is rejected;
  // simultaneous next/prev cancel each other.
  always_comb begin
    req_ok  = 1'b0;
    req_tgt = mode_q;
    if (bus.load_en) begin
      if (int'(bus.load_mode) < NUM_MODES) begin
        if (bus.mode_enable[bus.load_mode]) begin
          req_tgt = bus.load_mode;
          req_ok  = (bus.load_mode != mode_q);
        end
      end
    end else if (bus.next_edge && !bus.prev_edge) begin
      req_tgt = nxt_tgt;
      req_ok  = nxt_ok;
    end else if (bus.prev_edge && !bus.next_edge) begin
      req_tgt = prv_tgt;
      req_ok  = prv_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= MODE_W'(RESET_MODE);
      tgt_q  <= MODE_W'(RESET_MODE);
      mute_q <= 1'b0;
      busy_q <= 1'b0;
      chg_q  <= 1'b0;
      wcnt   <= '0;
      hcnt   <= '0;
    end else begin
      chg_q <= 1'b0;
      case (state)
        IDLE: if (req_ok) begin
          tgt_q  <= req_tgt;
          mute_q <= 1'b1;
          busy_q <= 1'b1;
          wcnt   <= '0;
          state  <= MUTE_WAIT;
        end
        // wcnt counts completed wait cycles; the last allowed one forces the switch.
        MUTE_WAIT: if (bus.mute_ack || wcnt == ACK_LAST) state <= SWITCH;
                   else wcnt <= wcnt + WCW'(1);
        SWITCH: begin
          mode_q <= tgt_q;
          chg_q  <= 1'b1;
          hcnt   <= '0;
          state  <= HOLD;
        end
        HOLD: if (hcnt == HOLD_LAST) begin
          mute_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end else hcnt <= hcnt + HCW'(1);
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mode     = mode_q;
  assign bus.mute_req = mute_q;
  assign bus.busy     = busy_q;
  assign bus.changed  = chg_q;
endmodule

// File: tb/tb_wave_mode_seq.sv
// Bench for wave_mode_seq: table of request transactions with hand-derived
// results, hand sequences for timeout/late ack, dropped requests and reset in
// flight, then random traffic. Every cycle is also compared with an event-time
// reference model of the mute/switch timeline.
module tb_wave_mode_seq;
  localparam int N  = 4;
  localparam int H  = 16;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wave_mode_if #(.NUM_MODES(N)) bus ();
  wave_mode_seq #(.NUM_MODES(N), .RESET_MODE(0), .HOLD_CYCLES(H), .ACK_TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] en = '1;

  // reference model: times of acceptance / mode switch on a global cycle axis
  int cyc = 0;
  int m_mode = 0, m_tgt = 0, m_acc = 0, m_sw = -1;
  bit m_busy = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Spec rule: next = smallest enabled index above mode, else smallest enabled;
  // prev = largest enabled below mode, else largest. -1 means no-op.
  function automatic int exp_target(int md, logic [N-1:0] e, bit ld, int lm, bit nx, bit pv);
    int up, dn, lo, hi, t;
    up = -1; dn = -1; lo = -1; hi = -1;
    if (ld) return (lm < N && e[lm] && lm != md) ? lm : -1;
    if (nx == pv) return -1;
    for (int i = 0; i < N; i++) if (e[i]) begin
      if (lo < 0) lo = i;
      hi = i;
      if (i > md && up < 0) up = i;
      if (i < md) dn = i;
    end
    if (nx) t = (up >= 0) ? up : lo;
    else    t = (dn >= 0) ? dn : hi;
    return (t < 0 || t == md) ? -1 : t;
  endfunction

  task automatic model_edge(bit ld, int lm, bit nx, bit pv, bit ack);
    int tg;
    if (!m_busy) begin
      tg = exp_target(m_mode, en, ld, lm, nx, pv);
      if (tg >= 0) begin
        m_busy = 1; m_acc = cyc; m_sw = -1; m_tgt = tg;
      end
    end else if (m_sw < 0) begin
      if (ack || cyc - m_acc == TO) m_sw = cyc + 1;
    end else if (cyc == m_sw) m_mode = m_tgt;
    else if (cyc == m_sw + H) m_busy = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_busy = 0; m_sw = -1;
  endtask

  task automatic step(bit ld, int lm, bit nx, bit pv, bit ack);
    @(negedge clk);
    bus.load_en = ld; bus.load_mode = 2'(lm); bus.next_edge = nx;
    bus.prev_edge = pv; bus.mute_ack = ack; bus.mode_enable = en;
    @(posedge clk);
    cyc++;
    model_edge(ld, lm, nx, pv, ack);
    #1;
    chk("mode", 32'(bus.mode), 32'(m_mode));
    chk("mute_req", 32'(bus.mute_req), 32'(m_busy));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("changed", 32'(bus.changed), 32'(m_sw == cyc));
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mode", 32'(bus.mode), 0);
    chk("rst_mute_req", 32'(bus.mute_req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_changed", 32'(bus.changed), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] en;
    bit ld; int lm; bit nx; bit pv;
    int exp_mode; bit acc;
  } vec_t;
  vec_t tbl[$];

  // One request with mute_ack tied high, then drain; checks final mode,
  // changed position relative to the request edge and mute_req duration.
  task automatic txn(vec_t v, int idx);
    int chg_at, mute_n;
    chg_at = -1; mute_n = 0;
    en = v.en;
    step(v.ld, v.lm, v.nx, v.pv, 1'b1);
    if (bus.mute_req) mute_n++;
    for (int k = 1; k <= H + 5; k++) begin
      step(0, 0, 0, 0, 1'b1);
      if (bus.mute_req) mute_n++;
      if (bus.changed && chg_at < 0) chg_at = k;
    end
    chk($sformatf("tbl%0d_mode", idx), 32'(bus.mode), 32'(v.exp_mode));
    chk($sformatf("tbl%0d_changed_at", idx), 32'(chg_at), v.acc ? 32'd2 : -32'sd1);
    chk($sformatf("tbl%0d_mute_cycles", idx), 32'(mute_n), v.acc ? 32'(2 + H) : 32'd0);
  endtask

  // next_edge with ack low except at step ack_at; changed must appear at exp_idx.
  task automatic ack_seq(int ack_at, int exp_idx, string name);
    int chg_at;
    chg_at = -1;
    step(0, 0, 1, 0, 1'b0);
    for (int k = 1; k <= TO + H + 4; k++) begin
      step(0, 0, 0, 0, k == ack_at);
      if (bus.changed && chg_at < 0) chg_at = k;
    end
    chk(name, 32'(chg_at), 32'(exp_idx));
  endtask

  initial begin
    bus.load_en = 0; bus.load_mode = '0; bus.next_edge = 0; bus.prev_edge = 0;
    bus.mute_ack = 0; bus.mode_enable = en;

    tbl.push_back('{4'b1111, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{4'b1111, 0, 0, 1, 0, 2, 1});
    tbl.push_back('{4'b1111, 0, 0, 1, 0, 3, 1});
    tbl.push_back('{4'b1111, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{4'b1111, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{4'b1010, 0, 0, 1, 0, 3, 1});
    tbl.push_back('{4'b1010, 0, 0, 1, 0, 1, 1});
    tbl.push_back('{4'b1010, 0, 0, 0, 1, 3, 1});
    tbl.push_back('{4'b1111, 1, 2, 1, 0, 2, 1});
    tbl.push_back('{4'b1111, 1, 0, 0, 0, 0, 1});
    tbl.push_back('{4'b1011, 1, 2, 0, 0, 0, 0});
    tbl.push_back('{4'b1111, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{4'b0000, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{4'b1111, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{4'b1111, 1, 2, 0, 0, 2, 1});
    tbl.push_back('{4'b0100, 0, 0, 1, 0, 2, 0});
    tbl.push_back('{4'b0100, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{4'b1011, 0, 0, 1, 0, 3, 1});
    tbl.push_back('{4'b0001, 0, 0, 0, 1, 0, 1});
    tbl.push_back('{4'b0001, 0, 0, 1, 0, 0, 0});

    async_rst();
    foreach (tbl[i]) txn(tbl[i], i);

    // requests during HOLD are dropped: mode 0 -> 1 only
    en = 4'b1111;
    step(0, 0, 1, 0, 1);
    for (int k = 1; k <= H + 5; k++) step(0, 0, k == 5, k == 9, 1);
    chk("drop_busy_mode", 32'(bus.mode), 1);

    // forced switch after the full timeout, then an ack at wait cycle 10
    ack_seq(-1, TO + 1, "timeout_changed_at");
    ack_seq(10, 11, "late_ack_changed_at");

    // reset in MUTE_WAIT, then in HOLD, then a normal request
    step(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
    async_rst();
    step(0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 1);
    async_rst();
    txn('{4'b1111, 0, 0, 1, 0, 1, 1}, 99);

    // random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      bit ld, nx, pv;
      int lm;
      if (k % 40 == 0) en = 4'($urandom);
      ld = ($urandom_range(0, 9) == 0);
      lm = $urandom_range(0, N - 1);
      nx = ($urandom_range(0, 5) == 0);
      pv = ($urandom_range(0, 5) == 0);
      if (ld && !en[lm]) begin nx = 0; pv = 0; end
      step(ld, lm, nx, pv, $urandom_range(0, 4) < 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wave_mode_seq.md
Name: wave_mode_seq

Overview:
Parametrised waveform-mode sequencer for the synth voice path, replacing a fixed four-mode cycler. It steps forward or backward through NUM_MODES oscillator modes, skipping modes masked off by mode_enable, and accepts direct loads. Each change is wrapped in a mute handshake with the oscillator/output stage so switching never produces a click: request mute, wait for acknowledge or timeout, switch, then hold mute before release.

Parameters:
NUM_MODES, 4, number of selectable modes (>=2)
MODE_W, $clog2(NUM_MODES), mode index width (derived, not overridden)
RESET_MODE, 0, mode index after reset (< NUM_MODES)
HOLD_CYCLES, 16, cycles mute_req stays high after the switch (>=1)
ACK_TIMEOUT, 255, max cycles spent in MUTE_WAIT without mute_ack (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
next_edge  input  1  one-cycle pulse: step to next enabled mode
prev_edge  input  1  one-cycle pulse: step to previous enabled mode
load_en  input  1  one-cycle pulse: jump to load_mode
load_mode  input  MODE_W  target index for load_en
mode_enable  input  NUM_MODES  bit i=1 means mode i is selectable
mute_ack  input  1  output stage is muted/at zero crossing
mode  output  MODE_W  current mode index (registered)
mute_req  output  1  request output stage to mute (registered)
busy  output  1  high whenever state != IDLE
changed  output  1  one-cycle pulse in the first cycle mode shows the new value

Behaviour:
- Reset (async, any state): mode=RESET_MODE, mute_req=0, changed=0, busy=0, state=IDLE, counters=0, latched target discarded.
- States: IDLE, MUTE_WAIT, SWITCH, HOLD.
- IDLE request priority: load_en > next_edge > prev_edge. next_edge and prev_edge together without load_en: both ignored.
- next: target = first enabled index after mode, ascending, wrapping NUM_MODES-1 -> 0. prev: descending, wrapping 0 -> NUM_MODES-1. Current mode itself is not checked as a candidate until the wrap returns to it.
- load: ignored if load_mode >= NUM_MODES or mode_enable[load_mode]=0.
- No-op when: no enabled mode other than current, mode_enable all zero, or target == mode. No-op: stay IDLE, no mute_req, no changed.
- Valid request sampled at edge E0: target latched, state -> MUTE_WAIT, mute_req=1 from E0.
- MUTE_WAIT: cycle counter increments each cycle; exit to SWITCH at the edge where mute_ack=1 is sampled, or when counter reaches ACK_TIMEOUT (forced switch). mute_ack high at E1 -> SWITCH after E1.
- SWITCH (one cycle): at its ending edge E2, mode <= target, changed=1 for exactly E2..E3, state -> HOLD.
- HOLD: mute_req held for HOLD_CYCLES cycles counted from E2. Then state -> IDLE and mute_req=0 at E2+HOLD_CYCLES.
- Minimum latency (ack already high): mode updates 2 cycles after the request edge. Total busy time = 2 + HOLD_CYCLES cycles.
- Requests arriving while busy=1 are dropped, not queued. First request accepted is the one sampled in IDLE.
- mode_enable changes take effect on the next request only. Disabling the current mode does not move mode. mode_enable is sampled only in IDLE when computing the target.
- mute_ack is ignored outside MUTE_WAIT.
- mode never leaves 0..NUM_MODES-1.

Test Plan:
- Reset with RESET_MODE=0, then next_edge x4, mute_ack tied 1, enable=4'b1111 -> mode 1,2,3,0; each change has changed pulse 2 cycles after request and mute_req high 2+16 cycles.
- enable=4'b1010, mode=1, next_edge -> mode 3. Then next_edge -> mode 1 (wrap, skip 0 and 2). Then prev_edge -> mode 3.
- mute_ack held 0, next_edge -> mute_req high, mode switches after 255 cycles in MUTE_WAIT; mute_ack asserted at cycle 10 in a rerun -> switch at cycle 10.
- load_en with load_mode=2, next_edge same cycle -> mode 2. load_mode=2 with enable[2]=0 -> no mute_req, no change. next+prev together -> ignored.
- next_edge while busy (during HOLD) -> dropped, mode advances once only. enable=4'b0100 with mode=2 -> next_edge is a no-op.
- Assert rst during MUTE_WAIT and during HOLD -> mode=RESET_MODE, mute_req=0, busy=0 immediately. A subsequent request behaves normally.
